// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: two-cycle tagged requests, a 2-stage add/sub pipe,
// an iterative shifter behind a small queue, and a merged response FIFO.
module calc2_port_responder #(
  parameter int SHQ_DEPTH = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        busy
);

  localparam int SHQ_AW = $clog2(SHQ_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic {S_IDLE, S_OP2} fe_state_t;

  typedef logic [SHQ_AW-1:0] shq_ptr_t;
  typedef logic [SHQ_AW:0]   shq_cnt_t;
  typedef logic [RSP_AW-1:0] rsp_ptr_t;
  typedef logic [RSP_AW:0]   rsp_cnt_t;

  localparam shq_cnt_t SHQ_FULL = shq_cnt_t'(SHQ_DEPTH);

  typedef struct packed {
    logic        is_left;
    logic [31:0] val;
    logic [4:0]  amt;
    logic [1:0]  tag;
  } shq_entry_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } rsp_entry_t;

  // ---------------- front-end FSM ----------------
  fe_state_t   state, state_nxt;
  logic        lat_en, dispatch;
  logic [3:0]  lat_cmd;
  logic [31:0] lat_op1;
  logic [1:0]  lat_tag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_cmd_in != 4'd0) state_nxt = S_OP2;
      S_OP2:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lat_en   = 1'b0;
    dispatch = 1'b0;
    case (state)
      S_IDLE: lat_en   = (req_cmd_in != 4'd0);
      S_OP2:  dispatch = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      lat_cmd <= '0;
      lat_op1 <= '0;
      lat_tag <= '0;
    end else if (lat_en) begin
      lat_cmd <= req_cmd_in;
      lat_op1 <= req_data_in;
      lat_tag <= req_tag_in;
    end
  end

  // ---------------- dispatch ----------------
  shq_cnt_t shq_count;
  logic     is_shift, shq_push, pipe_push;

  assign is_shift  = (lat_cmd == CMD_SHL) || (lat_cmd == CMD_SHR);
  assign shq_push  = dispatch && is_shift && (shq_count != SHQ_FULL);
  assign pipe_push = dispatch && !shq_push;

  // ---------------- add/sub pipe ----------------
  logic        s1_valid, s1_rej;
  logic [3:0]  s1_cmd;
  logic [31:0] s1_op1, s1_op2;
  logic [1:0]  s1_tag;
  logic [1:0]  s1_resp;
  logic [31:0] s1_data;
  logic [32:0] s1_sum;
  logic        s2_valid;
  rsp_entry_t  s2_ent;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_rej   <= 1'b0;
      s1_cmd   <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= pipe_push;
      if (pipe_push) begin
        s1_rej <= is_shift;  // shift that found the queue full
        s1_cmd <= lat_cmd;
        s1_op1 <= lat_op1;
        s1_op2 <= req_data_in;
        s1_tag <= lat_tag;
      end
    end
  end

  assign s1_sum = {1'b0, s1_op1} + {1'b0, s1_op2};

  always_comb begin
    s1_resp = RESP_ERR;
    s1_data = '0;
    if (!s1_rej) begin
      case (s1_cmd)
        CMD_ADD: if (!s1_sum[32]) begin
          s1_resp = RESP_OK;
          s1_data = s1_sum[31:0];
        end
        CMD_SUB: if (s1_op2 <= s1_op1) begin
          s1_resp = RESP_OK;
          s1_data = s1_op1 - s1_op2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_ent   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_ent <= '{resp: s1_resp, data: s1_data, tag: s1_tag};
    end
  end

  // ---------------- shift queue ----------------
  // The executing entry stays at the head until its result is pushed, so it counts toward full.
  shq_entry_t shq_mem [SHQ_DEPTH];
  shq_ptr_t   shq_wr, shq_rd;
  shq_entry_t shq_head;
  logic       shq_pop;

  // NOTE: queue storage is not reset; pointers and counts alone define which entries are live.
  always_ff @(posedge c_clk) begin
    if (shq_push)
      shq_mem[shq_wr] <= '{is_left: (lat_cmd == CMD_SHL), val: lat_op1,
                          amt: req_data_in[4:0], tag: lat_tag};
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      shq_wr    <= '0;
      shq_rd    <= '0;
      shq_count <= '0;
    end else begin
      if (shq_push) shq_wr <= shq_wr + shq_ptr_t'(1);
      if (shq_pop)  shq_rd <= shq_rd + shq_ptr_t'(1);
      shq_count <= shq_count + shq_cnt_t'(shq_push) - shq_cnt_t'(shq_pop);
    end
  end

  assign shq_head = shq_mem[shq_rd];

  // ---------------- iterative shifter ----------------
  logic        sh_active, sh_is_left, sh_nop;
  logic [31:0] sh_val;
  logic [4:0]  sh_cnt;
  logic [1:0]  sh_tag;
  logic        push_a, push_s;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      sh_active  <= 1'b0;
      sh_is_left <= 1'b0;
      sh_nop     <= 1'b0;
      sh_val     <= '0;
      sh_cnt     <= '0;
      sh_tag     <= '0;
    end else if (!sh_active) begin
      if (shq_count != '0) begin
        sh_active  <= 1'b1;
        sh_is_left <= shq_head.is_left;
        sh_val     <= shq_head.val;
        sh_tag     <= shq_head.tag;
        // An amount of 0 still spends one cycle, just without moving the value.
        sh_nop     <= (shq_head.amt == '0);
        sh_cnt     <= (shq_head.amt == '0) ? 5'd1 : shq_head.amt;
      end
    end else if (sh_cnt != '0) begin
      sh_cnt <= sh_cnt - 5'd1;
      if (!sh_nop) sh_val <= sh_is_left ? {sh_val[30:0], 1'b0} : {1'b0, sh_val[31:1]};
    end else begin
      sh_active <= 1'b0;
    end
  end

  assign push_a  = s2_valid;
  assign push_s  = sh_active && (sh_cnt == '0);
  assign shq_pop = push_s;

  // ---------------- response FIFO ----------------
  rsp_entry_t rsp_mem [RSP_DEPTH];
  rsp_ptr_t   rsp_wr, rsp_rd, rsp_wr_s;
  rsp_cnt_t   rsp_count;
  logic       rsp_pop;

  // Same-cycle pushes: the add-pipe entry takes the lower slot and is answered first.
  assign rsp_wr_s = rsp_wr + rsp_ptr_t'(push_a);
  assign rsp_pop  = (rsp_count != '0);

  always_ff @(posedge c_clk) begin
    if (push_a) rsp_mem[rsp_wr] <= s2_ent;
    if (push_s) rsp_mem[rsp_wr_s] <= '{resp: RESP_OK, data: sh_val, tag: sh_tag};
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rsp_wr    <= '0;
      rsp_rd    <= '0;
      rsp_count <= '0;
    end else begin
      rsp_wr    <= rsp_wr + rsp_ptr_t'(push_a) + rsp_ptr_t'(push_s);
      if (rsp_pop) rsp_rd <= rsp_rd + rsp_ptr_t'(1);
      rsp_count <= rsp_count + rsp_cnt_t'(push_a) + rsp_cnt_t'(push_s) - rsp_cnt_t'(rsp_pop);
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (rsp_pop) begin
      out_resp <= rsp_mem[rsp_rd].resp;
      out_data <= rsp_mem[rsp_rd].data;
      out_tag  <= rsp_mem[rsp_rd].tag;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end
  end

  assign busy = (state != S_IDLE) | s1_valid | s2_valid | (shq_count != '0)
              | sh_active | (rsp_count != '0);

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: stimulus pushes expected responses tagged
// with their arrival cycle; a negedge monitor matches every presented response.
module tb_calc2_port_responder;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        busy;

  calc2_port_responder dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .req_tag_in (req_tag_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: retire overdue expectations, then match any presented response by arrival cycle.
  always @(negedge c_clk) begin
    int idx;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp: tag %0d data 0x%0h expected at cycle %0d but it did not arrive",
                 sb[i].tag, sb[i].data, sb[i].cyc);
        sb.delete(i);
      end
    end
    if (out_resp != 2'd0) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) if (sb[i].cyc == cyc) idx = i;
      if (idx < 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: resp %0d data 0x%0h tag %0d at cycle %0d, none expected",
                 out_resp, out_data, out_tag, cyc);
      end else begin
        check("rsp_resp", out_resp, sb[idx].resp);
        check("rsp_data", out_data, sb[idx].data);
        check("rsp_tag",  out_tag,  sb[idx].tag);
        sb.delete(idx);
      end
    end
  end

  always @(posedge c_clk) begin
    if (reset && (dut.rsp_count == 4'd8) && (dut.push_a || dut.push_s)) begin
      errors++;
      $display("FAIL rsp_fifo_overflow: push while full at cycle %0d", cyc);
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that samples op2.
  task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [1:0] tag, input int lat, input logic [1:0] er,
                      input logic [31:0] ed);
    int t;
    req_cmd_in  = cmd;
    req_data_in = op1;
    req_tag_in  = tag;
    @(posedge c_clk); #1;
    req_cmd_in  = 4'hF;  // must be ignored in the operand-2 cycle
    req_data_in = op2;
    req_tag_in  = ~tag;
    @(posedge c_clk); #1;
    t = cyc;
    req_cmd_in  = 4'd0;
    req_data_in = '0;
    req_tag_in  = '0;
    if (lat > 0) sb.push_back(exp_t'{cyc: t + lat, resp: er, data: ed, tag: tag});
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(posedge c_clk); #1;
      n++;
    end
    check("drain_busy", busy, 1'b0);
    repeat (2) @(posedge c_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    repeat (3) @(posedge c_clk);
    #1;
    check("reset_resp", out_resp, 2'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_tag",  out_tag,  2'd0);
    check("reset_busy", busy,     1'b0);
    reset = 1'b1;
    @(posedge c_clk); #1;

    // 1: basic add, 3-edge latency
    send(4'd1, 32'h30, 32'h20, 2'd1, 3, 2'd1, 32'h50);
    check("busy_inflight", busy, 1'b1);
    wait_idle(50);

    // 2: overflow, underflow, good sub back to back
    send(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 3, 2'd2, 32'h0);
    send(4'd2, 32'h5, 32'h6, 2'd3, 3, 2'd2, 32'h0);
    send(4'd2, 32'h6, 32'h5, 2'd0, 3, 2'd1, 32'h1);
    wait_idle(50);

    // 3: long shl overtaken by a following add
    send(4'd5, 32'h1, 32'h3F, 2'd0, 34, 2'd1, 32'h8000_0000);
    send(4'd1, 32'h1, 32'h1, 2'd3, 3, 2'd1, 32'h2);
    wait_idle(100);

    // 4: five shr by 31; the fifth finds the queue full
    send(4'd6, 32'hFFFF_FFFF, 32'h1F, 2'd0, 34,  2'd1, 32'h1);
    send(4'd6, 32'hFFFF_FFFF, 32'h1F, 2'd1, 65,  2'd1, 32'h1);
    send(4'd6, 32'hFFFF_FFFF, 32'h1F, 2'd2, 96,  2'd1, 32'h1);
    send(4'd6, 32'hFFFF_FFFF, 32'h1F, 2'd3, 127, 2'd1, 32'h1);
    send(4'd6, 32'hFFFF_FFFF, 32'h1F, 2'd0, 3,   2'd2, 32'h0);
    wait_idle(300);

    // 5: invalid command, then shift by zero
    send(4'd9, 32'h1, 32'h1, 2'd2, 3, 2'd2, 32'h0);
    send(4'd5, 32'hA5, 32'h0, 2'd1, 4, 2'd1, 32'hA5);
    wait_idle(50);

    // 7: add-pipe and shifter push in the same cycle; add is answered first
    send(4'd5, 32'h3, 32'h4, 2'd2, 8, 2'd1, 32'h30);
    send(4'd2, 32'h9, 32'h4, 2'd1, 3, 2'd1, 32'h5);
    send(4'd1, 32'h7, 32'h8, 2'd3, 3, 2'd1, 32'hF);
    wait_idle(50);

    // 6: reset in the middle of a shift by 20 discards it
    send(4'd5, 32'h1, 32'h14, 2'd1, 0, 2'd0, 32'h0);
    repeat (8) @(posedge c_clk);
    #1;
    check("busy_shifting", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midreset_resp", out_resp, 2'd0);
    check("midreset_busy", busy, 1'b0);
    repeat (2) @(posedge c_clk);
    #1;
    reset = 1'b1;
    repeat (30) @(posedge c_clk);
    #1;
    check("postreset_busy", busy, 1'b0);
    send(4'd1, 32'h2, 32'h3, 2'd1, 3, 2'd1, 32'h5);
    wait_idle(50);

    repeat (5) @(posedge c_clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
